// File: rtl/timer_event_ctrl_if.sv
// Bus between the timer-side logic and the event controller: terminal pulse,
// threshold and acknowledge in, interrupt status out.
interface timer_event_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             cnt_one;
    logic [WIDTH-1:0] thresh;
    logic             irq_ack;
    logic             irq;
    logic [WIDTH-1:0] evt_cnt;
    logic             overflow;
    logic [1:0]       state_out;

    // Controller side
    modport slave (
        input  cnt_one,
        input  thresh,
        input  irq_ack,
        output irq,
        output evt_cnt,
        output overflow,
        output state_out
    );

    // Host / stimulus side
    modport master (
        output cnt_one,
        output thresh,
        output irq_ack,
        input  irq,
        input  evt_cnt,
        input  overflow,
        input  state_out
    );
endinterface

// File: rtl/timer_event_ctrl.sv
// Counts timer expiries (rising edges of cnt_one) and raises a sticky
// interrupt every thresh expiries; flags overflow on an unacknowledged repeat.
module timer_event_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                i_clk,
    input  logic                rst_n,
    input  logic                enable,
    timer_event_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COUNT   = 2'b01,
        PENDING = 2'b10
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             irq;
    logic             irq_n;
    logic             overflow;
    logic             overflow_n;
    logic [WIDTH-1:0] evt_cnt;
    logic [WIDTH-1:0] evt_cnt_n;
    logic [WIDTH-1:0] thresh_q;
    logic [WIDTH-1:0] thresh_q_n;
    logic             cnt_one_d;

    logic             event_c;
    logic             hit_c;
    logic [WIDTH-1:0] thresh_eff_c;

    // Rising-edge detect on the terminal pulse; threshold 0 behaves as 1
    assign event_c      = enable & bus.cnt_one & ~cnt_one_d;
    assign hit_c        = event_c & (evt_cnt == WIDTH'(thresh_q - WIDTH'(1)));
    assign thresh_eff_c = (bus.thresh == '0) ? WIDTH'(1) : bus.thresh;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq       <= 1'b0;
            overflow  <= 1'b0;
            evt_cnt   <= '0;
            thresh_q  <= WIDTH'(1);
            cnt_one_d <= 1'b0;
        end else begin
            state     <= state_n;
            irq       <= irq_n;
            overflow  <= overflow_n;
            evt_cnt   <= evt_cnt_n;
            thresh_q  <= thresh_q_n;
            cnt_one_d <= bus.cnt_one;
        end
    end

    // Next-state and next-output logic; disable overrides hit and ack
    always_comb begin
        state_n    = state;
        irq_n      = irq;
        overflow_n = overflow;
        evt_cnt_n  = evt_cnt;
        thresh_q_n = thresh_q;

        if (!enable) begin
            state_n    = IDLE;
            irq_n      = 1'b0;
            overflow_n = 1'b0;
            evt_cnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    // Events during the wake-up cycle are dropped
                    state_n    = COUNT;
                    irq_n      = 1'b0;
                    overflow_n = 1'b0;
                    evt_cnt_n  = '0;
                    thresh_q_n = thresh_eff_c;
                end
                COUNT: begin
                    if (hit_c) begin
                        state_n    = PENDING;
                        irq_n      = 1'b1;
                        evt_cnt_n  = '0;
                        thresh_q_n = thresh_eff_c;
                    end else if (event_c) begin
                        evt_cnt_n = WIDTH'(evt_cnt + WIDTH'(1));
                    end
                end
                PENDING: begin
                    if (hit_c) begin
                        // A new interrupt while one is outstanding: overflow
                        // unless the old one is acked on this very edge
                        evt_cnt_n  = '0;
                        thresh_q_n = thresh_eff_c;
                        overflow_n = ~bus.irq_ack;
                    end else begin
                        if (event_c) begin
                            evt_cnt_n = WIDTH'(evt_cnt + WIDTH'(1));
                        end
                        if (bus.irq_ack) begin
                            state_n    = COUNT;
                            irq_n      = 1'b0;
                            overflow_n = 1'b0;
                        end
                    end
                end
                default: begin
                    state_n    = IDLE;
                    irq_n      = 1'b0;
                    overflow_n = 1'b0;
                    evt_cnt_n  = '0;
                end
            endcase
        end
    end

    // Registered outputs onto the bus
    assign bus.irq       = irq;
    assign bus.evt_cnt   = evt_cnt;
    assign bus.overflow  = overflow;
    assign bus.state_out = state;

endmodule

// File: tb/tb_timer_event_ctrl.sv
// Self-checking bench for timer_event_ctrl: directed stimulus, a per-cycle
// behavioural model, and literal expectations at key points.
module tb_timer_event_ctrl;

    localparam int unsigned WIDTH = 4;

    logic i_clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    timer_event_ctrl_if #(.WIDTH(WIDTH)) bus ();

    timer_event_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk  (i_clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: active flag, outstanding interrupt, count in period
    bit m_active = 0;
    bit m_irq    = 0;
    bit m_ovf    = 0;
    bit m_prev   = 0;
    int m_cnt    = 0;
    int m_period = 1;

    always @(posedge i_clk or negedge rst_n) begin
        bit ev;
        bit fire;
        if (!rst_n) begin
            m_active = 0; m_irq = 0; m_ovf = 0; m_prev = 0;
            m_cnt = 0; m_period = 1;
        end else begin
            ev = enable && bus.cnt_one && !m_prev;
            m_prev = bus.cnt_one;
            if (!enable) begin
                m_active = 0; m_irq = 0; m_ovf = 0; m_cnt = 0;
            end else if (!m_active) begin
                m_active = 1;
                m_cnt = 0;
                m_period = (bus.thresh == 0) ? 1 : int'(bus.thresh);
            end else begin
                fire = ev && (m_cnt + 1 == m_period);
                if (ev) m_cnt = fire ? 0 : m_cnt + 1;
                if (fire) begin
                    m_period = (bus.thresh == 0) ? 1 : int'(bus.thresh);
                    m_ovf = m_irq && !bus.irq_ack;
                    m_irq = 1;
                end else if (m_irq && bus.irq_ack) begin
                    m_irq = 0;
                    m_ovf = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge i_clk) begin
        chk("model.irq", 32'(bus.irq), 32'(m_irq));
        chk("model.evt_cnt", 32'(bus.evt_cnt), 32'(m_cnt));
        chk("model.overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("model.state", 32'(bus.state_out),
            32'(!m_active ? 0 : (m_irq ? 2 : 1)));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic pulse();
        bus.cnt_one = 1'b1;
        tick(1);
        bus.cnt_one = 1'b0;
        tick(1);
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
    endtask

    task automatic outs(input string name, input logic i, input int c,
                        input logic o, input int s);
        chk({name, ".irq"}, 32'(bus.irq), 32'(i));
        chk({name, ".evt_cnt"}, 32'(bus.evt_cnt), 32'(c));
        chk({name, ".overflow"}, 32'(bus.overflow), 32'(o));
        chk({name, ".state"}, 32'(bus.state_out), 32'(s));
    endtask

    initial begin
        bus.cnt_one = 1'b0;
        bus.thresh  = 4'd3;
        bus.irq_ack = 1'b0;
        tick(2);
        outs("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(1);
        enable = 1'b1;
        tick(1);
        outs("wake", 0, 0, 0, 1);

        // Basic fire with thresh=3
        pulse();
        outs("basic1", 0, 1, 0, 1);
        pulse();
        outs("basic2", 0, 2, 0, 1);
        bus.cnt_one = 1'b1;
        tick(1);
        outs("basic3", 1, 0, 0, 2);
        bus.cnt_one = 1'b0;
        tick(1);
        ack();
        outs("basic_ack", 0, 0, 0, 1);

        // Held level counts once
        bus.cnt_one = 1'b1;
        tick(5);
        bus.cnt_one = 1'b0;
        tick(1);
        outs("held", 0, 1, 0, 1);

        // Overflow with thresh=2
        enable = 1'b0;
        bus.thresh = 4'd2;
        tick(1);
        outs("disable", 0, 0, 0, 0);
        enable = 1'b1;
        tick(1);
        pulse();
        pulse();
        outs("ovf2", 1, 0, 0, 2);
        pulse();
        outs("ovf3", 1, 1, 0, 2);
        pulse();
        outs("ovf4", 1, 0, 1, 2);
        ack();
        outs("ovf_ack", 0, 0, 0, 1);

        // Simultaneous ack and hit with thresh=1
        enable = 1'b0;
        bus.thresh = 4'd1;
        tick(1);
        enable = 1'b1;
        tick(1);
        pulse();
        outs("sim1", 1, 0, 0, 2);
        bus.cnt_one = 1'b1;
        bus.irq_ack = 1'b1;
        tick(1);
        bus.cnt_one = 1'b0;
        bus.irq_ack = 1'b0;
        tick(1);
        outs("sim_ack_hit", 1, 0, 0, 2);
        pulse();
        outs("sim_ovf", 1, 0, 1, 2);

        // Enable drop in PENDING with overflow set
        enable = 1'b0;
        tick(1);
        outs("abort", 0, 0, 0, 0);

        // Threshold change mid-period
        bus.thresh = 4'd3;
        enable = 1'b1;
        tick(1);
        pulse();
        outs("tch1", 0, 1, 0, 1);
        bus.thresh = 4'd2;
        pulse();
        outs("tch2", 0, 2, 0, 1);
        pulse();
        outs("tch3", 1, 0, 0, 2);
        ack();
        pulse();
        outs("tch4", 0, 1, 0, 1);
        pulse();
        outs("tch5", 1, 0, 0, 2);
        ack();

        // thresh=0 acts as 1 from the following period
        bus.thresh = 4'd0;
        pulse();
        pulse();
        outs("t0a", 1, 0, 0, 2);
        ack();
        pulse();
        outs("t0b", 1, 0, 0, 2);
        ack();
        pulse();
        outs("t0c", 1, 0, 0, 2);
        ack();

        // Asynchronous reset mid-count
        enable = 1'b0;
        bus.thresh = 4'd3;
        tick(1);
        enable = 1'b1;
        tick(1);
        pulse();
        pulse();
        outs("precnt", 0, 2, 0, 1);
        rst_n = 1'b0;
        #1;
        outs("async_rst", 0, 0, 0, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
